// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for the symmetric 7-band matrix (20, -13, 6, -1) of order N.
// Loads N integer b samples, sweeps in place until converged or MAX_ITER, then streams x.
module gsim_band_solver #(
    parameter int N        = 16,
    parameter int B_W      = 16,
    parameter int X_W      = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 64,
    parameter int TOL      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    input  logic signed [B_W-1:0] b_in,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic signed [X_W-1:0] x_out,
    output logic [7:0]            iter_cnt,
    output logic                  converged
);
    // state   | meaning
    // S_IDLE  | waiting for first b sample
    // S_LOAD  | collecting b[1..N-1]
    // S_SOLVE | one x[i] update per cycle, N cycles per sweep
    // S_OUT   | streaming x[0..N-1]
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SOLVE = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int IW = $clog2(N);
    localparam int AW = X_W + 8;
    localparam int PW = AW + 32;
    localparam logic [IW-1:0]        LAST  = IW'(N - 1);
    localparam logic [7:0]           MAX8  = 8'(MAX_ITER);
    localparam logic [X_W:0]         TOLV  = (X_W + 1)'(TOL);
    localparam logic signed [AW-1:0] C13   = AW'(13);
    localparam logic signed [AW-1:0] C6    = AW'(6);
    localparam logic signed [PW-1:0] RECIP = PW'(214748365);
    localparam logic signed [PW-1:0] RND   = PW'(1) <<< 31;
    localparam logic signed [PW-1:0] XMAXP = (PW'(1) <<< (X_W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] XMINP = -(PW'(1) <<< (X_W - 1));

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q;
    logic [7:0]            iter_q;
    logic                  conv_q;
    logic [X_W:0]          max_q;
    logic signed [X_W-1:0] xo_q;
    logic signed [X_W-1:0] x_q [N];
    logic signed [B_W-1:0] b_q [N];

    logic signed [X_W-1:0] xm1, xm2, xm3, xp1, xp2, xp3, x_old, x_new;
    logic signed [B_W-1:0] b_cur;
    logic signed [AW-1:0]  s1, s2, s3, acc;
    logic signed [PW-1:0]  prod, q;
    logic signed [X_W:0]   dlt;
    logic [X_W:0]          dabs, max_now;
    logic                  conv_now, sweep_end, sweep_done;
    logic [7:0]            iter_next;

    // Neighbour fetch; indices outside 0..N-1 stay at zero.
    always_comb begin
        xm1 = '0; xm2 = '0; xm3 = '0;
        xp1 = '0; xp2 = '0; xp3 = '0;
        x_old = '0;
        b_cur = '0;
        for (int k = 0; k < N; k++) begin
            if (k == int'(idx_q) - 1) xm1 = x_q[k];
            if (k == int'(idx_q) - 2) xm2 = x_q[k];
            if (k == int'(idx_q) - 3) xm3 = x_q[k];
            if (k == int'(idx_q) + 1) xp1 = x_q[k];
            if (k == int'(idx_q) + 2) xp2 = x_q[k];
            if (k == int'(idx_q) + 3) xp3 = x_q[k];
            if (k == int'(idx_q)) begin
                x_old = x_q[k];
                b_cur = b_q[k];
            end
        end
    end

    always_comb begin
        s1   = AW'(xm1) + AW'(xp1);
        s2   = AW'(xm2) + AW'(xp2);
        s3   = AW'(xm3) + AW'(xp3);
        acc  = (AW'(b_cur) <<< FRAC) + C13 * s1 - C6 * s2 + s3;
        // Divide by 20 as a reciprocal multiply, rounding half up.
        prod = PW'(acc) * RECIP + RND;
        q    = prod >>> 32;
        if (q > XMAXP)      x_new = XMAXP[X_W-1:0];
        else if (q < XMINP) x_new = XMINP[X_W-1:0];
        else                x_new = q[X_W-1:0];
        dlt        = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
        dabs       = dlt[X_W] ? -dlt : dlt;
        max_now    = (idx_q == '0 || dabs > max_q) ? dabs : max_q;
        conv_now   = (max_now <= TOLV);
        iter_next  = iter_q + 8'd1;
        sweep_end  = (idx_q == LAST);
        sweep_done = sweep_end && (conv_now || iter_next == MAX8);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_en) state_d = S_LOAD;
            S_LOAD:  if (in_en && idx_q == LAST) state_d = S_SOLVE;
            S_SOLVE: if (sweep_done) state_d = S_OUT;
            S_OUT:   if (idx_q == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            max_q   <= '0;
            xo_q    <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (in_en) begin
                    b_q[0] <= b_in;
                    idx_q  <= IW'(1);
                    iter_q <= '0;
                    conv_q <= 1'b0;
                    for (int k = 0; k < N; k++) x_q[k] <= '0;
                end
                S_LOAD: if (in_en) begin
                    b_q[idx_q] <= b_in;
                    idx_q      <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                S_SOLVE: begin
                    x_q[idx_q] <= x_new;
                    max_q      <= max_now;
                    if (sweep_end) begin
                        idx_q  <= '0;
                        iter_q <= iter_next;
                        conv_q <= conv_now;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_OUT: begin
                    xo_q  <= x_old;
                    idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy      = (state_q == S_SOLVE) || (state_q == S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign x_out     = out_valid ? x_old : xo_q;
    assign iter_cnt  = iter_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_gsim_band_solver.sv
// Directed bench for gsim_band_solver: three builds (default, MAX_ITER=2, N=8)
// with a reference Gauss-Seidel model feeding an expected-x scoreboard.
module tb_gsim_band_solver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic signed [15:0] bin = '0;
    int sel = 0;

    always #5 clk = ~clk;

    logic        rdy0, bsy0, ov0, cv0, rdy1, bsy1, ov1, cv1, rdy2, bsy2, ov2, cv2;
    logic [31:0] x0, x1, x2;
    logic [7:0]  it0, it1, it2;

    gsim_band_solver u0 (.clk(clk), .reset(reset), .in_en(en && sel == 0), .b_in(bin),
        .in_ready(rdy0), .busy(bsy0), .out_valid(ov0), .x_out(x0), .iter_cnt(it0), .converged(cv0));
    gsim_band_solver #(.MAX_ITER(2)) u1 (.clk(clk), .reset(reset), .in_en(en && sel == 1), .b_in(bin),
        .in_ready(rdy1), .busy(bsy1), .out_valid(ov1), .x_out(x1), .iter_cnt(it1), .converged(cv1));
    gsim_band_solver #(.N(8)) u2 (.clk(clk), .reset(reset), .in_en(en && sel == 2), .b_in(bin),
        .in_ready(rdy2), .busy(bsy2), .out_valid(ov2), .x_out(x2), .iter_cnt(it2), .converged(cv2));

    logic        rdy, bsy, ov, cvg;
    logic [31:0] xo;
    logic [7:0]  itc;
    always_comb begin
        case (sel)
            1:       begin rdy = rdy1; bsy = bsy1; ov = ov1; xo = x1; itc = it1; cvg = cv1; end
            2:       begin rdy = rdy2; bsy = bsy2; ov = ov2; xo = x2; itc = it2; cvg = cv2; end
            default: begin rdy = rdy0; bsy = bsy0; ov = ov0; xo = x0; itc = it0; cvg = cv0; end
        endcase
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rx [16];
    logic [31:0] last_exp = '0;
    int out_cnt = 0;
    int bvec [16];
    int m_it;
    bit m_cv;
    logic signed [95:0] mx_x [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic signed [95:0] nb(input int j, input int n);
        if (j < 0 || j >= n) return '0;
        return mx_x[j];
    endfunction

    // Reference sweep of the specified fixed-point update; pushes expected x.
    task automatic run_model(input int n, input int maxit);
        logic signed [95:0] acc, p, xn, d, mx;
        for (int k = 0; k < 16; k++) mx_x[k] = '0;
        m_it = 0;
        m_cv = 1'b0;
        while (!m_cv && m_it < maxit) begin
            mx = '0;
            for (int i = 0; i < n; i++) begin
                acc = 96'(bvec[i]) * 65536 + 13 * (nb(i - 1, n) + nb(i + 1, n))
                      - 6 * (nb(i - 2, n) + nb(i + 2, n)) + (nb(i - 3, n) + nb(i + 3, n));
                p  = acc * 96'sd214748365 + 96'sd2147483648;
                xn = p >>> 32;
                if (xn > 96'sd2147483647) xn = 96'sd2147483647;
                if (xn < -96'sd2147483648) xn = -96'sd2147483648;
                d = xn - mx_x[i];
                if (d < 0) d = -d;
                if (d > mx) mx = d;
                mx_x[i] = xn;
            end
            m_it++;
            m_cv = (mx <= 2);
        end
        for (int i = 0; i < n; i++) exp_q.push_back(mx_x[i][31:0]);
    endtask

    always @(negedge clk) begin
        if (ov) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("x_out", xo, e);
            if (out_cnt < 16) rx[out_cnt] = xo;
            last_exp = e;
            out_cnt++;
        end
    end

    task automatic send(input int n, input bit gaps);
        int c = 0;
        out_cnt = 0;
        for (int i = 0; i < n; ) begin
            if (gaps && c % 3 == 2) begin
                en = 1'b0;
            end else begin
                en  = 1'b1;
                bin = 16'(bvec[i]);
                i++;
            end
            c++;
            @(posedge clk); #1;
        end
        en = 1'b0;
    endtask

    // Waits for the frame to stream out; optionally drives junk in_en while busy.
    task automatic wait_frame(input int n, input bit junk);
        int cyc = 0;
        while (!(out_cnt >= n && !bsy) && cyc < 3000) begin
            en  = junk && bsy && (out_cnt < n - 3);
            bin = 16'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("out_count", 32'(out_cnt), 32'(n));
        check("idle_after_out", {29'd0, rdy, bsy, ov}, 32'b100);
    endtask

    task automatic set_ones();
        for (int i = 0; i < 16; i++) bvec[i] = 4;
        bvec[0] = 12; bvec[1] = -1; bvec[2] = 5;
        bvec[13] = 5; bvec[14] = -1; bvec[15] = 12;
    endtask

    task automatic set_golden();
        int g [16] = '{3, -7, 12, 0, 5, -2, 9, -11, 4, 6, -1, 8, -5, 2, 10, -3};
        for (int i = 0; i < 16; i++) bvec[i] = g[i];
    endtask

    task automatic check_near_one();
        int dev = 0;
        for (int i = 0; i < 16; i++) begin
            int d = int'(rx[i]) - 65536;
            if (d < 0) d = -d;
            if (d > dev) dev = d;
        end
        check("x_near_one", 32'(dev <= 256), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 32'(rdy), 32'd1);
        check("rst_busy", 32'(bsy), 32'd0);
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_x_out", xo, 32'd0);
        check("rst_iter_cnt", 32'(itc), 32'd0);
        check("rst_converged", 32'(cvg), 32'd0);

        // all-zero b
        for (int i = 0; i < 16; i++) bvec[i] = 0;
        run_model(16, 64);
        send(16, 1'b0);
        wait_frame(16, 1'b0);
        check("zero_iter", 32'(itc), 32'd1);
        check("zero_conv", 32'(cvg), 32'd1);

        // x = 1.0 pattern
        set_ones();
        run_model(16, 64);
        send(16, 1'b0);
        wait_frame(16, 1'b0);
        check("ones_iter", 32'(itc), 32'(m_it));
        check("ones_conv", 32'(cvg), 32'(m_cv));
        check_near_one();
        check("x_hold", xo, last_exp);

        // gapped load, junk in_en during SOLVE/OUT
        run_model(16, 64);
        send(16, 1'b1);
        wait_frame(16, 1'b1);
        check("gap_iter", 32'(itc), 32'(m_it));
        check_near_one();

        // reset in the middle of SOLVE
        send(16, 1'b0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        check("midrst_ready_busy_ov", {29'd0, rdy, bsy, ov}, 32'b100);
        run_model(16, 64);
        send(16, 1'b0);
        wait_frame(16, 1'b0);
        check("resend_iter", 32'(itc), 32'(m_it));
        check_near_one();

        // golden frame
        set_golden();
        run_model(16, 64);
        send(16, 1'b0);
        wait_frame(16, 1'b0);
        check("gold_iter", 32'(itc), 32'(m_it));
        check("gold_conv", 32'(cvg), 32'(m_cv));

        // MAX_ITER = 2 build
        sel = 1;
        run_model(16, 2);
        send(16, 1'b0);
        wait_frame(16, 1'b0);
        check("mi2_iter", 32'(itc), 32'd2);
        check("mi2_conv", 32'(cvg), 32'd0);

        // N = 8 build, zero b
        sel = 2;
        for (int i = 0; i < 16; i++) bvec[i] = 0;
        run_model(8, 64);
        send(8, 1'b0);
        wait_frame(8, 1'b0);
        check("n8_iter", 32'(itc), 32'd1);
        check("n8_conv", 32'(cvg), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
